// File: rtl/rand_arbiter.sv
// -----------------------------------------------------------------------------
// rand_arbiter
//
// Round-robin arbiter that hands out bytes from one shared 13-bit Fibonacci
// LFSR to up to four game-logic requesters. Every granted draw advances the
// LFSR STEPS times, so each consumer gets a fresh byte. The byte is delivered
// with a one-cycle rvalid strobe and a matching one-hot grant bit.
//
// Optional feature (compile-time macro RAND_SEED_LOAD_EN):
//   adds seed_load/seed_in so the LFSR can be reseeded while IDLE.
//
// Ports:
//   clk        in   1     rising-edge clock
//   resetn     in   1     synchronous, active-low reset
//   req        in   NREQ  per-requester draw request (level)
//   grant      out  NREQ  one-hot, high for the single DONE cycle
//   rdata      out  8     random byte, valid with rvalid, held otherwise
//   rvalid     out  1     one-cycle delivery strobe
//   busy       out  1     high whenever the FSM is not IDLE
//   seed_load  in   1     reseed request (RAND_SEED_LOAD_EN only)
//   seed_in    in   13    reseed value, 0 maps to SEED (RAND_SEED_LOAD_EN only)
// -----------------------------------------------------------------------------
module rand_arbiter #(
    parameter int          NREQ  = 3,
    parameter logic [12:0] SEED  = 13'h0007,
    parameter int          STEPS = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [7:0]      rdata,
    output logic            rvalid,
    output logic            busy
`ifdef RAND_SEED_LOAD_EN
    ,
    input  logic            seed_load,
    input  logic [12:0]     seed_in
`endif
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [12:0]     r;
    logic [12:0]     r_shifted;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   pick;
    logic            pick_valid;
    logic [3:0]      cnt;
    logic            seed_go;
    logic [12:0]     seed_value;

    // Fibonacci step: shift left, feedback taps 12,3,2,0 enter at bit 0.
    assign r_shifted = {r[11:0], r[12] ^ r[3] ^ r[2] ^ r[0]};

`ifdef RAND_SEED_LOAD_EN
    assign seed_go    = seed_load;
    assign seed_value = (seed_in == 13'd0) ? SEED : seed_in;
`else
    assign seed_go    = 1'b0;
    assign seed_value = SEED;
`endif

    // Round-robin search: first set req bit starting at rr_ptr+1, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_valid && req[idx]) begin
                pick       = PW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: state and datapath registers use non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // FSM next-state logic. A seed load in IDLE defers arbitration one cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (!seed_go && pick_valid) state_next = SHIFT;
            SHIFT: if (cnt == 4'(STEPS - 1))   state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: LFSR, pointer, selected requester, step counter, output byte.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: reset is synchronous and overrides everything, so a draw in
            // flight is dropped without any strobe.
            r      <= SEED;
            rr_ptr <= PW'(NREQ - 1);
            sel    <= '0;
            cnt    <= '0;
            rdata  <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (seed_go) begin
                        r <= seed_value;
                    end else if (pick_valid) begin
                        sel    <= pick;
                        rr_ptr <= pick;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r   <= r_shifted;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(STEPS - 1)) rdata <= r_shifted[7:0];
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only; no path from req.
    always_comb begin
        grant = '0;
        if (state == DONE) grant[sel] = 1'b1;
    end

    assign rvalid = (state == DONE);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_rand_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rand_arbiter
//
// Directed self-checking bench for rand_arbiter with default parameters
// (NREQ=3, SEED=13'h0007, STEPS=8). Expected bytes are hand-computed from the
// LFSR recurrence: eight steps from 13'h0007 give 13'h071C, byte 8'h1C.
// The seed-load scenario is compiled only when RAND_SEED_LOAD_EN is defined.
// -----------------------------------------------------------------------------
module tb_rand_arbiter;

    logic        clk;
    logic        resetn;
    logic [2:0]  req;
    logic [2:0]  grant;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
`ifdef RAND_SEED_LOAD_EN
    logic        seed_load;
    logic [12:0] seed_in;
`endif

    int total;
    int bad;

    rand_arbiter #(
        .NREQ (3),
        .SEED (13'h0007),
        .STEPS(8)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .req   (req),
        .grant (grant),
        .rdata (rdata),
        .rvalid(rvalid),
        .busy  (busy)
`ifdef RAND_SEED_LOAD_EN
        ,
        .seed_load(seed_load),
        .seed_in  (seed_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait up to 20 edges for rvalid; lat = edges waited, -1 on timeout.
    task automatic wait_strobe(output int lat, output logic [2:0] g,
                               output logic [7:0] d, output bit busy_all);
        lat      = -1;
        g        = '0;
        d        = '0;
        busy_all = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!busy) busy_all = 1'b0;
            if (rvalid) begin
                lat = i;
                g   = grant;
                d   = rdata;
                return;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req    = 3'b000;
        tick();
        tick();
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b want=%b", grant, 3'b000); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (dut.r !== 13'h0007) begin bad++; $display("FAIL reset_r got=%h want=0007", dut.r); end
        total++; if (dut.rr_ptr !== 2'd2) begin bad++; $display("FAIL reset_rr_ptr got=%0d want=2", dut.rr_ptr); end
        resetn = 1'b1;
    endtask

    task automatic test_single_draw();
        int         lat;
        logic [2:0] g;
        logic [7:0] d;
        bit         busy_all;
        req = 3'b001;
        tick();  // arbitration edge
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_rise got=%b want=1", busy); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL single_early_rvalid got=%b want=0", rvalid); end
        wait_strobe(lat, g, d, busy_all);
        total++; if (lat !== 8) begin bad++; $display("FAIL single_latency got=%0d want=8", lat); end
        total++; if (g !== 3'b001) begin bad++; $display("FAIL single_grant got=%b want=001", g); end
        total++; if (d !== 8'h1C) begin bad++; $display("FAIL single_rdata got=%h want=1c", d); end
        total++; if (dut.r !== 13'h071C) begin bad++; $display("FAIL single_r got=%h want=071c", dut.r); end
        total++; if (busy_all !== 1'b1) begin bad++; $display("FAIL single_busy_held got=%b want=1", busy_all); end
        req = 3'b000;
        tick();
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL single_strobe_len got=%b want=0", rvalid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b want=0", busy); end
        total++; if (rdata !== 8'h1C) begin bad++; $display("FAIL single_rdata_hold got=%h want=1c", rdata); end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_g [4];
        logic [2:0] seen_g [4];
        int         seen_t [4];
        int         n;
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req = 3'b111;
        n = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (rvalid) begin
                if (n < 4) begin
                    seen_g[n] = grant;
                    seen_t[n] = t;
                end
                n++;
            end
        end
        req = 3'b000;
        total++; if (n !== 4) begin bad++; $display("FAIL rr_strobe_count got=%0d want=4", n); end
        if (n >= 4) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (seen_g[k] !== exp_g[k]) begin
                    bad++; $display("FAIL rr_grant_%0d got=%b want=%b", k, seen_g[k], exp_g[k]);
                end
                total++;
                if (seen_t[k] !== 9 + 10 * k) begin
                    bad++; $display("FAIL rr_time_%0d got=%0d want=%0d", k, seen_t[k], 9 + 10 * k);
                end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_end_busy got=%b want=0", busy); end
    endtask

    task automatic test_drop_req();
        int         lat;
        logic [2:0] g;
        logic [7:0] d;
        bit         busy_all;
        req = 3'b010;
        tick();  // arbitration edge
        tick();
        tick();
        tick();
        req = 3'b000;
        wait_strobe(lat, g, d, busy_all);
        total++; if (lat !== 5) begin bad++; $display("FAIL drop_latency got=%0d want=5", lat); end
        total++; if (g !== 3'b010) begin bad++; $display("FAIL drop_grant got=%b want=010", g); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL drop_rvalid got=%b want=0", rvalid); end
    endtask

    task automatic test_reset_mid_draw();
        int         lat;
        logic [2:0] g;
        logic [7:0] d;
        bit         busy_all;
        bit         stale;
        req = 3'b001;
        tick();  // arbitration edge
        req = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        resetn = 1'b0;  // asserted during the 5th SHIFT cycle
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL midrst_grant got=%b want=000", grant); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid got=%b want=0", rvalid); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL midrst_rdata got=%h want=00", rdata); end
        resetn = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rvalid) stale = 1'b1;
        end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL midrst_stale_strobe got=%b want=0", stale); end
        req = 3'b001;
        tick();
        wait_strobe(lat, g, d, busy_all);
        req = 3'b000;
        total++; if (lat !== 8) begin bad++; $display("FAIL midrst_latency got=%0d want=8", lat); end
        total++; if (d !== 8'h1C) begin bad++; $display("FAIL midrst_rdata_redraw got=%h want=1c", d); end
        tick();
    endtask

    task automatic test_idle_hold();
        bit r_changed;
        bit d_changed;
        bit p_changed;
        bit strobe;
        r_changed = 1'b0; d_changed = 1'b0; p_changed = 1'b0; strobe = 1'b0;
        req = 3'b000;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (dut.r !== 13'h071C) r_changed = 1'b1;
            if (rdata !== 8'h1C) d_changed = 1'b1;
            if (dut.rr_ptr !== 2'd0) p_changed = 1'b1;
            if (rvalid !== 1'b0) strobe = 1'b1;
        end
        total++; if (r_changed) begin bad++; $display("FAIL idle_r got=%h want=071c", dut.r); end
        total++; if (d_changed) begin bad++; $display("FAIL idle_rdata got=%h want=1c", rdata); end
        total++; if (p_changed) begin bad++; $display("FAIL idle_rr_ptr got=%0d want=0", dut.rr_ptr); end
        total++; if (strobe) begin bad++; $display("FAIL idle_rvalid got=1 want=0"); end
    endtask

`ifdef RAND_SEED_LOAD_EN
    task automatic test_seed_load();
        int         lat;
        logic [2:0] g;
        logic [7:0] d;
        bit         busy_all;
        seed_load = 1'b1;
        seed_in   = 13'h0000;
        req       = 3'b001;
        tick();
        seed_load = 1'b0;
        total++; if (dut.r !== 13'h0007) begin bad++; $display("FAIL seed_r got=%h want=0007", dut.r); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL seed_no_arb got=%b want=0", busy); end
        total++; if (dut.rr_ptr !== 2'd0) begin bad++; $display("FAIL seed_rr_ptr got=%0d want=0", dut.rr_ptr); end
        tick();  // deferred arbitration edge
        wait_strobe(lat, g, d, busy_all);
        req = 3'b000;
        total++; if (lat !== 8) begin bad++; $display("FAIL seed_latency got=%0d want=8", lat); end
        total++; if (d !== 8'h1C) begin bad++; $display("FAIL seed_rdata got=%h want=1c", d); end
        tick();
    endtask
`endif

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        req    = 3'b000;
`ifdef RAND_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in   = 13'h0000;
`endif
        test_reset();
        test_single_draw();
        test_fairness();
        test_drop_req();
        test_reset_mid_draw();
        test_idle_hold();
`ifdef RAND_SEED_LOAD_EN
        test_seed_load();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
